ula_div: RTL
============

// Module: ula_div
// PURPOSE
//  Sequential restoring divider for the float datapath; inverse companion of the multiply ULA.
//  Computes quotient and remainder of a / b, one quotient bit per clock.
//  Uses the same start/done handshake as the multiply ULA.
//  Feeds the mantissa-divide step of the float unit.
// PARAMETERS
//  WIDTH  26  operand, quotient and remainder width in bits (mantissa width)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      request; sampled at posedge only in IDLE or DONE
//  a          in   WIDTH  dividend; captured on the accepting edge
//  b          in   WIDTH  divisor; captured on the accepting edge
//  busy       out  1      high while state is RUN (or FIX)
//  done       out  1      level; high in DONE until the next start is accepted
//  div_zero   out  1      high with done when the captured b was 0
//  quotient   out  WIDTH  valid while done=1; held until the next accept
//  remainder  out  WIDTH  valid while done=1; held until the next accept
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE. busy, done, div_zero, quotient, remainder and the internal counter all go to 0.
//  - FSM states: IDLE, RUN, (FIX), DONE.
//  - IDLE/DONE, start=1 at edge k:
//    - Capture a, b. Clear done and div_zero.
//    - If b!=0: rem_acc=0, q_acc=a, cnt=WIDTH, go RUN.
//    - If b==0: go DONE at edge k with quotient={WIDTH{1}}, remainder=a, div_zero=1.
//  - RUN, each edge:
//    - t = {rem_acc, q_acc[MSB]} - {1'b0, b}, computed at WIDTH+1 bits.
//    - If t >= 0: rem_acc=t[WIDTH-1:0] and shift in quotient bit 1. Otherwise keep the shifted rem_acc and shift in 0.
//    - cnt decrements each edge.
//    - On the edge where cnt reaches 0, go DONE (or FIX) and load the outputs.
//  - Latency (b!=0): done reads 1 in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accepting edge.
//  - Latency (b==0): done reads 1 in the cycle after edge k, i.e. 1 cycle.
//  - start while busy is ignored. Operands stay frozen and the operation completes unchanged.
//  - start held high in DONE starts a new operation each time DONE is re-entered. Benches pulse start for 1 cycle.
//  - a < b gives quotient=0, remainder=a. a==b gives quotient=1, remainder=0.
//  - No overflow is possible: quotient <= a always fits in WIDTH bits.
//  - reset_n low mid-RUN aborts immediately. After release the block is in IDLE and needs a fresh start.
// CONFIGURATION
//  ULA_DIV_SIGNED_EN undefined:
//   - Operands and results are unsigned.
//   - FIX state is absent.
//  ULA_DIV_SIGNED_EN defined:
//   - a and b are two's complement; RUN divides the magnitudes |a| and |b|.
//   - FIX is one extra cycle after RUN (latency WIDTH+1):
//     - quotient is negated if sign(a)^sign(b), so it truncates toward zero;
//     - remainder takes the sign of a.
//   - The b==0 path is unchanged: quotient={WIDTH{1}} (reads as -1), remainder=a.
//   - Most-negative / -1 returns quotient=most-negative, remainder=0, div_zero=0.
// TESTING
//  1. a=100, b=7, pulse start -> done after 26 cycles; quotient=14, remainder=2, div_zero=0.
//  2. a=5, b=9 -> quotient=0, remainder=5. Then a=9, b=9 -> quotient=1, remainder=0.
//  3. a=26'h3FFFFFF, b=1 -> quotient=26'h3FFFFFF, remainder=0. Also b=26'h3FFFFFF -> quotient=1, remainder=0.
//  4. a=123, b=0 -> done 1 cycle after accept; div_zero=1, quotient=26'h3FFFFFF, remainder=123.
//  5. start a=100, b=7, then re-pulse start with a=50, b=5 on cycle 10 -> ignored; result still 14 r 2.
//     Then reset_n=0 on cycle 5 of a new operation -> all outputs 0, state IDLE.
//  6. ULA_DIV_SIGNED_EN defined: a=-100, b=7 -> after 27 cycles quotient=-14, remainder=-2.
//     Also a=100, b=-7 -> quotient=-14, remainder=2.

Source files
------------

// File: rtl/ula_div.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Define ULA_DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle after RUN).
module ula_div #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
`ifdef ULA_DIV_SIGNED_EN
    StFix  = 2'd2,
`endif
    StDone = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  qacc_q, qacc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              div_zero_q, div_zero_d;
`ifdef ULA_DIV_SIGNED_EN
  logic              q_neg_q, q_neg_d;
  logic              a_neg_q, a_neg_d;
`endif

  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  rem_step;
  logic [WIDTH-1:0]  q_step;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;

  always_comb begin
`ifdef ULA_DIV_SIGNED_EN
    a_mag = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
    b_mag = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
`else
    a_mag = a_i;
    b_mag = b_i;
`endif
    // Sign bit of the (WIDTH+1)-bit trial difference decides the quotient bit.
    diff     = {rem_q, qacc_q[WIDTH-1]} - {1'b0, b_q};
    rem_step = diff[WIDTH] ? {rem_q[WIDTH-2:0], qacc_q[WIDTH-1]} : diff[WIDTH-1:0];
    q_step   = {qacc_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    rem_d       = rem_q;
    qacc_d      = qacc_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
`ifdef ULA_DIV_SIGNED_EN
    q_neg_d     = q_neg_q;
    a_neg_d     = a_neg_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          b_d        = b_mag;
          div_zero_d = 1'b0;
`ifdef ULA_DIV_SIGNED_EN
          q_neg_d    = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          a_neg_d    = a_i[WIDTH-1];
`endif
          if (b_i == '0) begin
            quotient_d  = '1;
            remainder_d = a_i;
            div_zero_d  = 1'b1;
            state_d     = StDone;
          end else begin
            rem_d   = '0;
            qacc_d  = a_mag;
            cnt_d   = CntW'(WIDTH);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d  = rem_step;
        qacc_d = q_step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
`ifdef ULA_DIV_SIGNED_EN
          state_d = StFix;
`else
          quotient_d  = q_step;
          remainder_d = rem_step;
          state_d     = StDone;
`endif
        end
      end
`ifdef ULA_DIV_SIGNED_EN
      StFix: begin
        quotient_d  = q_neg_q ? (~qacc_q + 1'b1) : qacc_q;
        remainder_d = a_neg_q ? (~rem_q + 1'b1) : rem_q;
        state_d     = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      b_q         <= '0;
      rem_q       <= '0;
      qacc_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef ULA_DIV_SIGNED_EN
      q_neg_q     <= 1'b0;
      a_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      qacc_q      <= qacc_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
`ifdef ULA_DIV_SIGNED_EN
      q_neg_q     <= q_neg_d;
      a_neg_q     <= a_neg_d;
`endif
    end
  end

`ifdef ULA_DIV_SIGNED_EN
  assign busy_o = (state_q == StRun) || (state_q == StFix);
`else
  assign busy_o = (state_q == StRun);
`endif
  assign done_o      = (state_q == StDone);
  assign div_zero_o  = div_zero_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule
